// File: rtl/ssbcc_uart_pkg.sv
// Shared state encodings and constant helpers for the SSBCC UART peripherals.
package ssbcc_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  // Number of bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/ssbcc_fifo_sync.sv
// Synchronous first-word-fall-through FIFO, depth 2**L2DEPTH, with write/pop strobes.
module ssbcc_fifo_sync #(
  parameter int WIDTH   = 8,
  parameter int L2DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_wr,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << L2DEPTH;
  localparam int PTR_W = L2DEPTH + 1;
  localparam int ADDR_W = (L2DEPTH > 0) ? L2DEPTH : 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              do_wr;
  logic              do_pop;

  // Full when the pointers differ only in their extra wrap bit.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = ((wr_ptr ^ rd_ptr) == PTR_W'(DEPTH));
  assign do_wr   = i_wr && !o_full;
  assign do_pop  = i_pop && !o_empty;

  generate
    if (L2DEPTH == 0) begin : g_single
      assign wr_addr = '0;
      assign rd_addr = '0;
    end else begin : g_multi
      assign wr_addr = wr_ptr[ADDR_W-1:0];
      assign rd_addr = rd_ptr[ADDR_W-1:0];
    end
  endgenerate

  assign o_data = mem[rd_addr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem[wr_addr] <= i_data;
    end
  end

endmodule

// File: rtl/uart_tx_outport.sv
// UART transmitter fed from a processor output port through a small FIFO.
module uart_tx_outport
  import ssbcc_uart_pkg::*;
#(
  parameter int BAUDMETHOD = 868,
  parameter int L2FIFO     = 4,
  parameter int NSTOP      = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_wr,
  output logic       o_busy,
  output logic       o_idle,
  output logic       o_overflow,
  input  logic       i_clr_ovf,
  output logic       o_uart_tx
);

  localparam int BAUD_W = clog2(BAUDMETHOD);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUDMETHOD - 1);
  localparam logic STOP_RELOAD = 1'(NSTOP - 1);

  uart_state_t       state;
  uart_state_t       state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_cnt_nxt;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_cnt_nxt;
  logic              stop_cnt;
  logic              stop_cnt_nxt;
  logic [7:0]        shifter;
  logic [7:0]        shifter_nxt;
  logic              tx_reg;
  logic              tx_nxt;
  logic              overflow;
  logic              pop;
  logic              baud_done;
  logic [7:0]        fifo_data;
  logic              fifo_full;
  logic              fifo_empty;

  ssbcc_fifo_sync #(
    .WIDTH  (8),
    .L2DEPTH(L2FIFO)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_wr   (i_wr),
    .i_pop  (pop),
    .o_data (fifo_data),
    .o_full (fifo_full),
    .o_empty(fifo_empty)
  );

  assign baud_done  = (baud_cnt == '0);
  assign o_busy     = fifo_full;
  assign o_idle     = fifo_empty && (state == S_IDLE);
  assign o_overflow = overflow;
  assign o_uart_tx  = tx_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shifter  <= '0;
      tx_reg   <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      shifter  <= shifter_nxt;
      tx_reg   <= tx_nxt;
    end
  end

  // Every bit period ends when the baud counter hits zero; the frame
  // advances only on those edges, otherwise the counter just counts down.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    shifter_nxt  = shifter;
    tx_nxt       = tx_reg;
    pop          = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shifter_nxt  = fifo_data;
          tx_nxt       = 1'b0;
          baud_cnt_nxt = BAUD_RELOAD;
          state_nxt    = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          tx_nxt       = shifter[0];
          shifter_nxt  = {1'b0, shifter[7:1]};
          bit_cnt_nxt  = 3'd7;
          baud_cnt_nxt = BAUD_RELOAD;
          state_nxt    = S_DATA;
        end else begin
          baud_cnt_nxt = baud_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_cnt_nxt = BAUD_RELOAD;
          if (bit_cnt == 3'd0) begin
            tx_nxt       = 1'b1;
            stop_cnt_nxt = STOP_RELOAD;
            state_nxt    = S_STOP;
          end else begin
            tx_nxt      = shifter[0];
            shifter_nxt = {1'b0, shifter[7:1]};
            bit_cnt_nxt = bit_cnt - 1'b1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (stop_cnt == 1'b0) begin
            // A queued byte starts its start bit on this very edge.
            if (!fifo_empty) begin
              pop          = 1'b1;
              shifter_nxt  = fifo_data;
              tx_nxt       = 1'b0;
              baud_cnt_nxt = BAUD_RELOAD;
              state_nxt    = S_START;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            stop_cnt_nxt = stop_cnt - 1'b1;
            baud_cnt_nxt = BAUD_RELOAD;
          end
        end else begin
          baud_cnt_nxt = baud_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // A dropped write beats a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (i_wr && fifo_full) begin
      overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_outport.sv
// Bench for uart_tx_outport: waveform-queue model checked every cycle plus literal spot checks.
module tb_uart_tx_outport;

  localparam int B     = 4;
  localparam int DEPTH = 4;
  localparam int NSTOP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = 8'h00;
  logic       wr = 1'b0;
  logic       clr = 1'b0;
  logic       busy, idle, ovf, tx;
  logic [7:0] data2 = 8'h00;
  logic       wr2 = 1'b0;
  logic       clr2 = 1'b0;
  logic       busy2, idle2, ovf2, tx2;

  int checks = 0;
  int errors = 0;

  logic [9:0]  t1_exp = 10'b1101001010;
  logic [10:0] t5_exp = 11'b11100000000;

  always #5 clk = ~clk;

  uart_tx_outport #(.BAUDMETHOD(B), .L2FIFO(2), .NSTOP(NSTOP)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_wr(wr),
    .o_busy(busy), .o_idle(idle), .o_overflow(ovf),
    .i_clr_ovf(clr), .o_uart_tx(tx)
  );

  uart_tx_outport #(.BAUDMETHOD(B), .L2FIFO(2), .NSTOP(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_wr(wr2),
    .o_busy(busy2), .o_idle(idle2), .o_overflow(ovf2),
    .i_clr_ovf(clr2), .o_uart_tx(tx2)
  );

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic w, input logic c);
    data = d;
    wr   = w;
    clr  = c;
    @(negedge clk);
    wr  = 1'b0;
    clr = 1'b0;
  endtask

  // Model: accepted bytes queue up; each started frame expands into its
  // per-cycle line samples, and the line is high whenever none remain.
  logic [7:0] mq[$];
  logic       wq[$];
  logic       m_tx = 1'b1;
  logic       m_active = 1'b0;
  logic       m_ovf = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        wq.delete();
        m_tx     = 1'b1;
        m_active = 1'b0;
        m_ovf    = 1'b0;
      end else begin
        logic       full_now;
        logic [7:0] b;
        full_now = (mq.size() == DEPTH);
        if (wq.size() == 0 && mq.size() > 0) begin
          b = mq.pop_front();
          for (int k = 0; k < B; k++) wq.push_back(1'b0);
          for (int i = 0; i < 8; i++)
            for (int k = 0; k < B; k++) wq.push_back(b[i]);
          for (int k = 0; k < NSTOP * B; k++) wq.push_back(1'b1);
        end
        if (wq.size() > 0) begin
          m_tx     = wq.pop_front();
          m_active = 1'b1;
        end else begin
          m_tx     = 1'b1;
          m_active = 1'b0;
        end
        if (wr && !full_now) mq.push_back(data);
        if (wr && full_now) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model_tx", tx, m_tx);
      checkOutput("model_busy", busy, mq.size() == DEPTH);
      checkOutput("model_idle", idle, !m_active && mq.size() == 0);
      checkOutput("model_ovf", ovf, m_ovf);
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_idle", idle, 1'b1);
    checkOutput("reset_ovf", ovf, 1'b0);
    rst = 1'b0;

    // Single byte 0xA5, sampled mid-bit.
    repeat (3) @(negedge clk);
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("t1_latency", tx, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 1) checkOutput("t1_bit", tx, t1_exp[i/4]);
      if (i == 39) checkOutput("t1_not_idle", idle, 1'b0);
      @(negedge clk);
    end
    checkOutput("t1_idle", idle, 1'b1);

    // Three back-to-back bytes.
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    repeat (38) @(negedge clk);
    checkOutput("t2_stop1", tx, 1'b1);
    @(negedge clk);
    checkOutput("t2_nogap", tx, 1'b0);
    repeat (82) @(negedge clk);
    checkOutput("t2_idle", idle, 1'b1);

    // Overflow: six writes, then write+clear while full, then clear.
    for (int n = 0; n < 6; n++) begin
      applyStimulus(8'h10 + 8'(n), 1'b1, 1'b0);
      if (n == 3) checkOutput("t3_busy4", busy, 1'b0);
      if (n == 4) checkOutput("t3_busy5", busy, 1'b1);
      if (n == 4) checkOutput("t3_noovf", ovf, 1'b0);
    end
    checkOutput("t3_ovf", ovf, 1'b1);
    applyStimulus(8'h99, 1'b1, 1'b1);
    checkOutput("t6_setwins", ovf, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("t3_clr", ovf, 1'b0);
    repeat (200) @(negedge clk);
    checkOutput("t3_idle", idle, 1'b1);

    // Asynchronous reset during the start bit of the second frame.
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("t4_prelow", tx, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("t4_async_tx", tx, 1'b1);
    checkOutput("t4_async_idle", idle, 1'b1);
    checkOutput("t4_async_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("t4_quiet_tx", tx, 1'b1);
    checkOutput("t4_quiet_idle", idle, 1'b1);

    // Two stop bits, byte 0x80.
    data2 = 8'h80;
    wr2   = 1'b1;
    @(negedge clk);
    wr2 = 1'b0;
    checkOutput("t5_latency", tx2, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 44; i++) begin
      if (i % 4 == 1) checkOutput("t5_bit", tx2, t5_exp[i/4]);
      if (i == 43) checkOutput("t5_not_idle", idle2, 1'b0);
      @(negedge clk);
    end
    checkOutput("t5_idle", idle2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
